// File: rtl/contador_pkg.sv
// Shared constants for the debounced up/down counter.
package contador_pkg;

    // Parameter defaults
    localparam int unsigned DEF_WIDTH      = 4;
    localparam int unsigned DEF_MAX        = (1 << DEF_WIDTH) - 1;
    localparam int unsigned DEF_DEB_CYCLES = 4;

    // Stability counter width: enough for DEB_CYCLES up to 255
    localparam int unsigned DEB_CNT_W = 8;

    // up_down encoding
    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // SATURATE encoding
    localparam int unsigned WRAP = 0;
    localparam int unsigned HOLD = 1;

    // Largest value representable in w bits
    function automatic int unsigned max_for(input int unsigned w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/contador_parametrizado_debounce_btn.sv
// Button front end: 2-flop synchroniser, stability-count debounce, rising-edge press pulse.
module debounce_btn
    import contador_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic btn_db,
    output logic press
);

    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

    logic [1:0]           sync_pipe;
    logic                 btn_s;
    logic [DEB_CNT_W-1:0] stab_cnt;
    logic                 db_q;

    assign btn_s = sync_pipe[1];

    // Two-flop synchroniser; bit 1 is the only copy used downstream
    always_ff @(posedge clk) begin
        if (reset) sync_pipe <= '0;
        else       sync_pipe <= {sync_pipe[0], btn};
    end

    // Accept a new level once it has differed from btn_db for DEB_CYCLES clocks in a row;
    // any return to the current level restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db   <= 1'b0;
            stab_cnt <= '0;
        end else if (btn_s != btn_db) begin
            if (stab_cnt == DEB_LAST) begin
                btn_db   <= btn_s;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end else begin
            stab_cnt <= '0;
        end
    end

    // Previous debounced level for 0->1 detection
    always_ff @(posedge clk) begin
        if (reset) db_q <= 1'b0;
        else       db_q <= btn_db;
    end

    // One-cycle step request in the cycle after btn_db rises
    assign press = btn_db & ~db_q;

endmodule

// File: rtl/contador_parametrizado.sv
// Debounced push-button up/down counter with load, enable, wrap/saturate and terminal pulse.
module contador_parametrizado
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned MAX        = max_for(WIDTH),
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned SATURATE   = WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] S,
    output logic             btn_db,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam bit               SAT   = (SATURATE == HOLD);

    logic             step;
    logic [WIDTH-1:0] s_next;
    logic             tc_next;

    debounce_btn #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn),
        .btn_db (btn_db),
        .press  (step)
    );

    // Next count: load beats step; limit steps wrap or hold and raise tc
    always_comb begin
        s_next  = S;
        tc_next = 1'b0;
        if (load) begin
            s_next = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (step && enable) begin
            if (up_down == UP) begin
                if (S >= MAX_V) begin
                    s_next  = SAT ? MAX_V : '0;
                    tc_next = 1'b1;
                end else begin
                    s_next = S + 1'b1;
                end
            end else begin
                if (S == '0) begin
                    s_next  = SAT ? '0 : MAX_V;
                    tc_next = 1'b1;
                end else begin
                    s_next = S - 1'b1;
                end
            end
        end
    end

    // Count and terminal-pulse registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            S  <= '0;
            tc <= 1'b0;
        end else begin
            S  <= s_next;
            tc <= tc_next;
        end
    end

endmodule

// File: tb/tb_contador_parametrizado.sv
// Directed plus randomized bench: two counter configurations share one stimulus stream.
module tb_contador_parametrizado;
    import contador_pkg::*;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset, btn, enable, up_down, load;
    logic [3:0] load_val;
    logic [3:0] s_a;
    logic [1:0] s_b;
    logic       tc_a, tc_b, db_a, db_b;

    int passed = 0;
    int total  = 0;

    // Behavioural reference state
    int m_b1, m_b2, m_db, m_dbp, m_run;
    int m_s[2];
    int m_tc[2];
    int mx[2]    = '{9, 3};
    int sat[2]   = '{1, 0};
    int wmask[2] = '{15, 3};

    always #5 clk = ~clk;

    // a: saturating 0..9 in 4 bits; b: wrapping 0..3 in 2 bits
    contador_parametrizado #(.WIDTH(4), .MAX(9), .DEB_CYCLES(DEB), .SATURATE(1)) dut_a (
        .clk(clk), .reset(reset), .btn(btn), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val), .S(s_a), .btn_db(db_a), .tc(tc_a)
    );

    contador_parametrizado #(.WIDTH(2), .MAX(3), .DEB_CYCLES(DEB), .SATURATE(0)) dut_b (
        .clk(clk), .reset(reset), .btn(btn), .enable(enable), .up_down(up_down),
        .load(load), .load_val(load_val[1:0]), .S(s_b), .btn_db(db_b), .tc(tc_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: button level seen two clocks late, accepted after DEB differing samples;
    // a step is the clock after the accepted level goes 0->1
    task automatic model_edge();
        int press, lv;
        press = (m_db == 1 && m_dbp == 0) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            m_tc[i] = 0;
            if (reset) begin
                m_s[i] = 0;
            end else if (load) begin
                lv = int'(load_val) & wmask[i];
                m_s[i] = (lv > mx[i]) ? mx[i] : lv;
            end else if (press == 1 && enable) begin
                if (up_down) begin
                    if (m_s[i] == mx[i]) begin m_tc[i] = 1; m_s[i] = sat[i] ? mx[i] : 0; end
                    else m_s[i] = m_s[i] + 1;
                end else begin
                    if (m_s[i] == 0) begin m_tc[i] = 1; m_s[i] = sat[i] ? 0 : mx[i]; end
                    else m_s[i] = m_s[i] - 1;
                end
            end
        end
        if (reset) begin
            m_b1 = 0; m_b2 = 0; m_db = 0; m_dbp = 0; m_run = 0;
        end else begin
            m_dbp = m_db;
            if (m_b2 != m_db) begin
                m_run = m_run + 1;
                if (m_run == DEB) begin m_db = m_b2; m_run = 0; end
            end else begin
                m_run = 0;
            end
            m_b2 = m_b1;
            m_b1 = int'(btn);
        end
    endtask

    // One clock: advance the model, then compare every output just after the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("S_a",  int'(s_a),  m_s[0]);
        chk("tc_a", int'(tc_a), m_tc[0]);
        chk("S_b",  int'(s_b),  m_s[1]);
        chk("tc_b", int'(tc_b), m_tc[1]);
        chk("btn_db_a", int'(db_a), m_db);
        chk("btn_db_b", int'(db_b), m_db);
    endtask

    // Clean press and release, counting tc pulses seen on each DUT
    task automatic press_btn(input logic ud, output int tca, output int tcb);
        tca = 0; tcb = 0;
        up_down = ud;
        btn = 1'b1;
        repeat (DEB + 3) begin tick(); tca += int'(tc_a); tcb += int'(tc_b); end
        btn = 1'b0;
        repeat (DEB + 3) begin tick(); tca += int'(tc_a); tcb += int'(tc_b); end
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int ta, tb, n, run;
        int glitch[4]   = '{1, 0, 1, 0};
        int wrap_exp[4] = '{1, 2, 3, 0};

        reset = 1'b1; btn = 1'b0; enable = 1'b1; up_down = 1'b1;
        load = 1'b0; load_val = 4'd0;
        repeat (2) tick();
        chk("reset_S", int'(s_a), 0);
        chk("reset_btn_db", int'(db_a), 0);
        chk("reset_tc", int'(tc_a), 0);
        reset = 1'b0;

        // Bounce: glitches never step; hold from edge k steps at k+6
        for (int i = 0; i < 4; i++) begin btn = glitch[i][0]; tick(); end
        btn = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("bounce_S", int'(s_a), (j >= 6) ? 1 : 0);
        end
        btn = 1'b0;
        repeat (10) tick();
        chk("release_no_step", int'(s_a), 1);

        // Up wrap on the 2-bit counter
        do_load(4'd0);
        for (int p = 0; p < 4; p++) begin
            press_btn(1'b1, ta, tb);
            chk("wrap_S_b", int'(s_b), wrap_exp[p]);
            chk("wrap_tc_b", tb, (p == 3) ? 1 : 0);
        end

        // Down saturate on the 0..9 counter
        do_load(4'd0);
        for (int p = 0; p < 2; p++) begin
            press_btn(1'b0, ta, tb);
            chk("sat_S_a", int'(s_a), 0);
            chk("sat_tc_a", ta, 1);
        end

        // Load with clamp in the same cycle as a step
        up_down = 1'b1;
        btn = 1'b1;
        n = 0;
        while (m_db == 0 && n < 20) begin tick(); n++; end
        chk("db_rise_wait", int'(db_a), 1);
        load = 1'b1; load_val = 4'd15;
        tick();
        load = 1'b0;
        chk("clamp_S_a", int'(s_a), 9);
        chk("clamp_tc_a", int'(tc_a), 0);
        tick();
        chk("step_discarded", int'(s_a), 9);
        btn = 1'b0;
        repeat (DEB + 3) tick();

        // Disabled presses are dropped
        enable = 1'b0;
        for (int p = 0; p < 3; p++) begin
            press_btn(1'b1, ta, tb);
            chk("disabled_S_a", int'(s_a), 9);
            chk("disabled_tc_a", ta, 0);
        end
        enable = 1'b1;

        // Reset at stability count 2 with btn held high
        up_down = 1'b1;
        btn = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("rst_mid_S", int'(s_a), (i >= 7) ? 1 : 0);
        end
        btn = 1'b0;
        repeat (DEB + 3) tick();

        // Randomized traffic against the model
        run = 0;
        for (int c = 0; c < 600; c++) begin
            if (run == 0) begin
                btn = 1'($urandom_range(0, 1));
                run = int'($urandom_range(1, 10));
            end
            run--;
            enable   = ($urandom_range(0, 9) != 0);
            up_down  = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 24) == 0);
            load_val = 4'($urandom_range(0, 15));
            reset    = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/contador_parametrizado.md
CONTADOR_PARAMETRIZADO -- requirements
Module: contador_parametrizado

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 1..16.
REQ-002 Parameter MAX, default 2**WIDTH-1: terminal value, legal range 1..2**WIDTH-1.
REQ-003 Parameter DEB_CYCLES, default 4: consecutive stable clocks required to accept a button level, legal range 1..255.
REQ-004 Parameter SATURATE, default 0: 0 = wrap at the limits, 1 = hold at the limits.
REQ-005 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port btn, input, 1: raw asynchronous, bouncing push-button; each accepted press is one count step.
REQ-008 Port enable, input, 1: when 0, count steps are ignored; load still acts.
REQ-009 Port up_down, input, 1: 1 = increment, 0 = decrement; sampled in the cycle the step is applied.
REQ-010 Port load, input, 1: synchronous parallel load strobe.
REQ-011 Port load_val, input, WIDTH: value written on load.
REQ-012 Port S, output, WIDTH: registered count value.
REQ-013 Port btn_db, output, 1: registered, debounced button level.
REQ-014 Port tc, output, 1: registered one-cycle pulse on a limit event.

Function
REQ-015 btn SHALL pass through a two-flop synchroniser before any other use.
- btn_db SHALL take the synchronised level only after that level has differed from btn_db for DEB_CYCLES consecutive clocks.
- Any reversion of the synchronised level SHALL clear the stability count.
REQ-016 A step request SHALL be a one-cycle pulse generated on each 0->1 transition of btn_db; 1->0 transitions and held presses SHALL NOT generate steps.
REQ-017 Latency: with btn held high from clock edge k, btn_db SHALL rise at edge k+1+DEB_CYCLES and S SHALL update at edge k+2+DEB_CYCLES.
REQ-018 Per-cycle priority SHALL be: reset > load > step (with enable=1) > hold.
REQ-019 load SHALL write load_val to S; if load_val > MAX, S SHALL take MAX. A step in the same cycle SHALL be discarded, and tc SHALL stay 0.
REQ-020 Up step behaviour:
- S<MAX: S+1.
- S=MAX, SATURATE=0: S becomes 0 and tc pulses.
- S=MAX, SATURATE=1: S holds MAX and tc pulses.
REQ-021 Down step behaviour:
- S>0: S-1.
- S=0, SATURATE=0: S becomes MAX and tc pulses.
- S=0, SATURATE=1: S holds 0 and tc pulses.
REQ-022 tc SHALL be high for exactly the one cycle after the limit step and 0 in all other cycles.
REQ-023 A step arriving while enable=0 SHALL be dropped, not queued.
REQ-024 All arithmetic SHALL be unsigned, modulo the MAX+1 range; S SHALL never exceed MAX.

Reset
REQ-025 On reset=1 at a clock edge:
- S, tc and btn_db SHALL become 0.
- Synchroniser flops, the stability counter and the edge-detect register SHALL become 0.
REQ-026 A reset arriving mid-debounce SHALL abandon the pending press; the press SHALL count only if btn is still stable high for DEB_CYCLES after reset is released.
REQ-027 Reset SHALL override load and step in the same cycle.

Structure
REQ-028 A shared package contador_pkg SHALL hold:
- the default values of WIDTH, MAX and DEB_CYCLES;
- the up_down encoding constants (UP=1, DOWN=0);
- the SATURATE encoding constants (WRAP=0, HOLD=1).
REQ-029 The synchroniser, debounce counter and edge detector SHALL be one sub-module, debounce_btn, with ports clk, reset, btn, btn_db and press.
REQ-030 The counter datapath SHALL be a single clocked process in contador_parametrizado, with no clock derived from btn.

Verification
REQ-031 Bounce test (WIDTH=4, DEB_CYCLES=4):
- btn toggles 1,0,1,0 on successive clocks, then is held high for 10 clocks.
- Required: S goes 0->1 exactly once, at edge k+6 after the hold starts.
- Required: no step from the glitches.
REQ-032 Up wrap (WIDTH=2, MAX=3, SATURATE=0): four accepted presses with up_down=1 -> S sequence 1,2,3,0, and tc pulses once, on the 3->0 step.
REQ-033 Down saturate (MAX=9, SATURATE=1): load_val=0 loaded, then two presses with up_down=0 -> S stays 0 and tc pulses on each press.
REQ-034 Load priority and clamp (MAX=9): load=1 with load_val=15 in the same cycle as a step pulse -> S=9, tc=0, and the step is discarded.
REQ-035 Reset mid-debounce: reset pulsed for 1 clock at stability count 2 with btn kept high -> S stays 0 until DEB_CYCLES+2 clocks after reset is released, then S=1.
REQ-036 enable=0 with three accepted presses -> S unchanged and tc never asserted.
